// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 1024x768 VGA timing constants and frame scheduler state encoding
package vga_timing_pkg;
   localparam int H_TOTAL             = 1344;
   localparam int V_TOTAL             = 806;
   localparam int V_BLNK_START        = 768;
   localparam int DEF_LAST_START_LINE = 800;
   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;
endpackage

// File: rtl/frame_tick_divider.sv
// frame_tick_divider: vblnk edge detection, frame counting and game-tick division
module frame_tick_divider (
   input  logic        clk,
   input  logic        rst,
   input  logic        vblnk,
   input  logic [3:0]  speed_div,
   output logic        vb_fall,
   output logic        tick_due,
   output logic [15:0] frame_cnt
);
   logic       vblnk_d;
   logic       vb_rise;
   logic [3:0] div_cnt;
   logic [3:0] div_max;
   assign vb_rise  = vblnk & ~vblnk_d;
   assign vb_fall  = ~vblnk & vblnk_d;
   assign div_max  = (speed_div == 4'd0) ? 4'd1 : speed_div;
   assign tick_due = vb_rise && ({1'b0, div_cnt} + 5'd1 >= {1'b0, div_max});
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         vblnk_d   <= 1'b0;
         div_cnt   <= '0;
         frame_cnt <= '0;
      end else begin
         vblnk_d <= vblnk;
         if (vb_rise) begin
            frame_cnt <= frame_cnt + 16'd1;
            div_cnt   <= tick_due ? 4'd0 : div_cnt + 4'd1;
         end
      end
endmodule

// File: rtl/vga_frame_scheduler.sv
// vga_frame_scheduler: grants game-logic engines one at a time during vblank, once per game tick
module vga_frame_scheduler
   import vga_timing_pkg::*;
#(
   parameter int N_CLIENTS       = 4,
   parameter int LAST_START_LINE = DEF_LAST_START_LINE,
   parameter int CW              = $clog2(N_CLIENTS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 vblnk,
   input  logic [15:0]          vcount,
   input  logic                 enable,
   input  logic [3:0]           speed_div,
   input  logic [N_CLIENTS-1:0] client_en,
   input  logic [N_CLIENTS-1:0] done,
   input  logic                 clr_overrun,
   output logic [N_CLIENTS-1:0] req,
   output logic                 tick,
   output logic                 busy,
   output logic                 overrun,
   output logic [15:0]          frame_cnt,
   output logic [CW-1:0]        cur_client
);
   logic [0:0]           state;
   logic [CW-1:0]        idx;
   logic [N_CLIENTS-1:0] en_q;
   logic                 vb_fall, tick_due, start, late, last, advance, set_ovr;
   frame_tick_divider u_div (
      .clk       (clk),
      .rst       (rst),
      .vblnk     (vblnk),
      .speed_div (speed_div),
      .vb_fall   (vb_fall),
      .tick_due  (tick_due),
      .frame_cnt (frame_cnt)
   );
   assign busy       = state == GRANT;
   assign cur_client = idx;
   assign start      = tick_due && enable && state == IDLE;
   assign late       = {16'd0, vcount} > LAST_START_LINE;
   assign last       = idx == CW'(N_CLIENTS - 1);
   // a disabled client is skipped; an enabled one advances only on its own done
   assign advance    = (req == '0 && !en_q[idx]) || (req[idx] && done[idx]);
   assign set_ovr    = (busy && vb_fall) || (start && late) || (tick_due && busy);
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state   <= IDLE;
         idx     <= '0;
         en_q    <= '0;
         req     <= '0;
         tick    <= 1'b0;
         overrun <= 1'b0;
      end else begin
         tick    <= start && !late;
         overrun <= set_ovr || (overrun && !clr_overrun);
         if (state == IDLE) begin
            if (start && !late) begin
               state <= GRANT;
               idx   <= '0;
               en_q  <= client_en;
            end
         end else if (vb_fall) begin
            state <= IDLE;
            idx   <= '0;
            req   <= '0;
         end else begin
            if (req == '0 && en_q[idx]) req <= N_CLIENTS'(1) << idx;
            if (advance) begin
               req   <= '0;
               idx   <= last ? '0 : idx + CW'(1);
               state <= last ? IDLE : GRANT;
            end
         end
      end
endmodule

// File: tb/tb_vga_frame_scheduler.sv
// tb_vga_frame_scheduler: directed scoreboard bench with short synthetic frames
module tb_vga_frame_scheduler;
   logic        clk = 1'b0, rst = 1'b0, vblnk = 1'b0, enable = 1'b0, clr_overrun = 1'b0;
   logic [15:0] vcount = '0;
   logic [3:0]  speed_div = 4'd1, client_en = 4'hf, done = '0, stall = '0;
   logic [3:0]  req;
   logic        tick, busy, overrun;
   logic [15:0] frame_cnt, f0;
   logic [1:0]  cur_client;
   int          n_cmp = 0, n_bad = 0, n_tick = 0, t0, blen;
   int          cnt [4];
   logic [3:0]  exp_q [$];
   logic [3:0]  seen = '0, req_prev = '0, e;

   vga_frame_scheduler dut (
      .clk         (clk),
      .rst         (rst),
      .vblnk       (vblnk),
      .vcount      (vcount),
      .enable      (enable),
      .speed_div   (speed_div),
      .client_en   (client_en),
      .done        (done),
      .clr_overrun (clr_overrun),
      .req         (req),
      .tick        (tick),
      .busy        (busy),
      .overrun     (overrun),
      .frame_cnt   (frame_cnt),
      .cur_client  (cur_client)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_seq(input logic [3:0] en);
      for (int i = 0; i < 4; i++) if (en[i]) exp_q.push_back(4'(1 << i));
   endtask

   task automatic frame(input int blank, input int active);
      vblnk = 1'b1; vcount = 16'd768;
      repeat (blank) @(negedge clk);
      vblnk = 1'b0; vcount = 16'd0;
      repeat (active) @(negedge clk);
   endtask

   task automatic wait_req(input logic [3:0] v, input string tag);
      for (int i = 0; i < 200 && req !== v; i++) @(negedge clk);
      chk(tag, req, v);
   endtask

   task automatic pulse_clr;
      clr_overrun = 1'b1;
      @(negedge clk);
      clr_overrun = 1'b0;
   endtask

   // engine model: each granted, non-stalled engine answers done after 10 req cycles
   initial forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         cnt[i]  = (req[i] && !stall[i]) ? cnt[i] + 1 : 0;
         done[i] = cnt[i] == 10;
      end
   end

   // scoreboard: every new grant must match the next expected client
   always @(negedge clk) begin
      if (tick) n_tick++;
      seen = seen | req;
      if (req != '0) chk("req_onehot", 32'($onehot(req)), 1);
      if (req != '0 && req_prev == '0) begin
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'h0;
         chk("req_order", req, e);
      end
      req_prev = req;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_req", req, 0);
      chk("rst_tick", tick, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
      chk("rst_cur_client", cur_client, 0);
      rst = 1'b1; enable = 1'b1;
      @(negedge clk);
      // full sequence, every engine enabled
      push_seq(4'hf);
      vblnk = 1'b1; vcount = 16'd768;
      @(negedge clk);
      chk("t1_tick", tick, 1);
      chk("t1_busy", busy, 1);
      chk("t1_no_req_yet", req, 0);
      @(negedge clk);
      chk("t1_first_req", req, 4'h1);
      chk("t1_tick_one_cycle", tick, 0);
      blen = 2;
      for (int i = 0; i < 200 && busy; i++) begin
         @(negedge clk);
         if (busy) blen++;
      end
      chk("t1_busy_len", blen, 44);
      chk("t1_queue_empty", exp_q.size(), 0);
      chk("t1_overrun", overrun, 0);
      chk("t1_cur_idle", cur_client, 0);
      repeat (10) @(negedge clk);
      vblnk = 1'b0; vcount = '0;
      repeat (10) @(negedge clk);
      // one tick per three frames
      speed_div = 4'd3; f0 = frame_cnt; t0 = n_tick;
      repeat (3) push_seq(4'hf);
      repeat (9) frame(60, 10);
      chk("t2_ticks", n_tick - t0, 3);
      chk("t2_frame_cnt", frame_cnt, 32'(f0 + 16'd9));
      chk("t2_queue_empty", exp_q.size(), 0);
      // partial enable mask
      speed_div = 4'd1; client_en = 4'b0101; seen = '0;
      push_seq(4'b0101);
      frame(60, 10);
      chk("t3_seen_mask", seen, 4'b0101);
      chk("t3_queue_empty", exp_q.size(), 0);
      client_en = 4'hf;
      // client 2 hangs, vblank ends and aborts the sequence
      stall = 4'b0100;
      push_seq(4'b0111);
      vblnk = 1'b1; vcount = 16'd768;
      wait_req(4'h4, "t4_req2_granted");
      repeat (3) @(negedge clk);
      vblnk = 1'b0; vcount = '0;
      @(negedge clk);
      chk("t4_abort_req", req, 0);
      chk("t4_abort_overrun", overrun, 1);
      chk("t4_abort_busy", busy, 0);
      chk("t4_abort_cur", cur_client, 0);
      chk("t4_queue_empty", exp_q.size(), 0);
      stall = '0;
      pulse_clr;
      chk("t4_overrun_cleared", overrun, 0);
      // tick due too late in the frame
      t0 = n_tick;
      vblnk = 1'b1; vcount = 16'd801;
      @(negedge clk);
      chk("t5_late_tick", tick, 0);
      chk("t5_late_overrun", overrun, 1);
      chk("t5_late_busy", busy, 0);
      repeat (5) @(negedge clk);
      chk("t5_late_no_ticks", n_tick - t0, 0);
      vblnk = 1'b0; vcount = '0;
      @(negedge clk);
      pulse_clr;
      chk("t5_overrun_cleared", overrun, 0);
      // set and clear together: set wins
      vblnk = 1'b1; vcount = 16'd801; clr_overrun = 1'b1;
      @(negedge clk);
      clr_overrun = 1'b0;
      chk("t5_set_wins", overrun, 1);
      vblnk = 1'b0; vcount = '0;
      @(negedge clk);
      pulse_clr;
      chk("t5_cleared_again", overrun, 0);
      // disabled scheduler drops ticks
      enable = 1'b0; t0 = n_tick;
      frame(60, 10);
      chk("t6_disabled_ticks", n_tick - t0, 0);
      chk("t6_disabled_busy", busy, 0);
      chk("t6_disabled_overrun", overrun, 0);
      enable = 1'b1;
      // async reset in the middle of client 1's grant
      push_seq(4'b0011);
      vblnk = 1'b1; vcount = 16'd768;
      wait_req(4'h2, "t7_req1_granted");
      rst = 1'b0;
      #1;
      chk("t7_async_req", req, 0);
      chk("t7_async_busy", busy, 0);
      chk("t7_async_frame_cnt", frame_cnt, 0);
      chk("t7_async_cur", cur_client, 0);
      chk("t7_async_overrun", overrun, 0);
      vblnk = 1'b0; vcount = '0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      push_seq(4'hf);
      frame(60, 10);
      chk("t7_restart_queue_empty", exp_q.size(), 0);
      chk("t7_restart_frame_cnt", frame_cnt, 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
